// File: rtl/idli_fetch_m.sv
// Instruction fetch: SQI sequential-read front end that streams encoding nibbles aligned to the sync counter.
// Optional DUMMY phase enabled with `define IDLI_FE_DUMMY_EN.
module idli_fetch_m #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        i_fe_gck,
  input  logic        i_ex_rst_n,
  output logic        o_fe_cs_n,
  output logic [3:0]  o_fe_sio_out,
  output logic        o_fe_sio_oe,
  input  logic [3:0]  i_fe_sio_in,
  output logic [1:0]  o_fe_ctr,
  output logic [3:0]  o_fe_enc,
  output logic        o_fe_enc_vld,
  output logic [15:0] o_fe_pc,
  input  logic        i_fe_redirect,
  input  logic [15:0] i_fe_redirect_addr
);

  typedef logic [1:0] ctr_t;
  typedef logic [3:0] data_t;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

  // Start one cycle early so the registered CS_n/sio_out land on the start counter value.
`ifdef IDLI_FE_DUMMY_EN
  localparam ctr_t START_CTR = 2'd0;
`else
  localparam ctr_t START_CTR = 2'd2;
`endif

  state_t            state;
  logic [2:0]        cnt;
  logic [15:0]       fetch_addr;
  logic [5:0][3:0]   addr_nibs;
  logic              wrap;
  logic              restart;

  assign addr_nibs = {7'b0, fetch_addr, 1'b0};
  assign wrap      = (state == DATA) && o_fe_enc_vld && (o_fe_pc == 16'hFFFF);
  assign restart   = (o_fe_ctr == 2'd3) && (i_fe_redirect || wrap);

  always_ff @(posedge i_fe_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      fetch_addr   <= RESET_ADDR;
      o_fe_ctr     <= 2'd0;
      o_fe_cs_n    <= 1'b1;
      o_fe_sio_out <= 4'h0;
      o_fe_sio_oe  <= 1'b0;
      o_fe_enc     <= 4'h0;
      o_fe_enc_vld <= 1'b0;
      o_fe_pc      <= RESET_ADDR;
    end else begin
      o_fe_ctr <= o_fe_ctr + 2'd1;
      if (restart) begin
        // External redirect beats the implicit wrap to 0; the nibble in flight is dropped.
        state        <= IDLE;
        fetch_addr   <= i_fe_redirect ? i_fe_redirect_addr : 16'h0000;
        o_fe_cs_n    <= 1'b1;
        o_fe_sio_out <= 4'h0;
        o_fe_sio_oe  <= 1'b0;
        o_fe_enc_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: if (o_fe_ctr == START_CTR) begin
            state        <= CMD;
            cnt          <= 3'd0;
            o_fe_cs_n    <= 1'b0;
            o_fe_sio_oe  <= 1'b1;
            o_fe_sio_out <= 4'h0;
          end
          CMD: if (cnt == 3'd0) begin
            cnt          <= 3'd1;
            o_fe_sio_out <= 4'h3;
          end else begin
            state        <= ADDR;
            cnt          <= 3'd0;
            o_fe_sio_out <= addr_nibs[5];
          end
          ADDR: if (cnt == 3'd5) begin
            cnt          <= 3'd0;
            o_fe_sio_out <= 4'h0;
`ifdef IDLI_FE_DUMMY_EN
            state        <= DUMMY;
`else
            state        <= DATA;
            o_fe_sio_oe  <= 1'b0;
`endif
          end else begin
            cnt          <= cnt + 3'd1;
            o_fe_sio_out <= addr_nibs[3'd4 - cnt];
          end
          DUMMY: if (cnt == 3'd1) begin
            state       <= DATA;
            o_fe_sio_oe <= 1'b0;
          end else begin
            cnt <= 3'd1;
          end
          DATA: begin
            o_fe_enc     <= data_t'(i_fe_sio_in);
            o_fe_enc_vld <= 1'b1;
            if (!o_fe_enc_vld)
              o_fe_pc <= fetch_addr;
            else if (o_fe_ctr == 2'd3)
              o_fe_pc <= o_fe_pc + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed bench for idli_fetch_m with a behavioural SQI SRAM; works with or without IDLI_FE_DUMMY_EN.
module tb_idli_fetch_m;
`ifdef IDLI_FE_DUMMY_EN
  localparam int HDR = 10, CS0 = 1, CSR = 2;
`else
  localparam int HDR = 8, CS0 = 3, CSR = 4;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cs_n, oe, vld, redirect = 1'b0;
  logic [3:0]  sio_out, enc, sio_in = 4'h0;
  logic [1:0]  ctr;
  logic [15:0] pc, redirect_addr = 16'h0;
  int tests = 0, failed = 0;

  idli_fetch_m #(.RESET_ADDR(16'h0010)) dut (
    .i_fe_gck(clk), .i_ex_rst_n(rst_n), .o_fe_cs_n(cs_n), .o_fe_sio_out(sio_out),
    .o_fe_sio_oe(oe), .i_fe_sio_in(sio_in), .o_fe_ctr(ctr), .o_fe_enc(enc),
    .o_fe_enc_vld(vld), .o_fe_pc(pc), .i_fe_redirect(redirect), .i_fe_redirect_addr(redirect_addr));

  always #5 clk = ~clk;

  // Memory content: nibble k (memory order) of the word at word address w.
  function automatic logic [3:0] mnib(input int w, input int k);
    int v;
    v = w * 7 + k * 3 + (w >> 4) + (w >> 16) * 9 + 5;
    return v[3:0];
  endfunction

  // SRAM model: captures the header while selected, then streams nibbles from the captured byte address.
  logic [23:0] m_baddr = 24'h0;
  int m_h = 0, m_j = 0;
  always @(negedge clk) begin
    if (cs_n) begin
      m_h = 0; m_j = 0;
    end else if (m_h < HDR) begin
      if (m_h >= 2 && m_h < 8) m_baddr = {m_baddr[19:0], sio_out};
      m_h++;
    end else begin
      sio_in = mnib(int'(m_baddr >> 1) + m_j / 4, m_j % 4);
      m_j++;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (cs_n !== 1'b1) begin failed++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    tests++; if (ctr !== 2'd0) begin failed++; $display("FAIL reset_ctr got %0d want 0", ctr); end
    tests++; if (sio_out !== 4'h0 || oe !== 1'b0) begin failed++; $display("FAIL reset_sio got %h/%b want 0/0", sio_out, oe); end
    tests++; if (enc !== 4'h0 || vld !== 1'b0) begin failed++; $display("FAIL reset_enc got %h/%b want 0/0", enc, vld); end
    tests++; if (pc !== 16'h0010) begin failed++; $display("FAIL reset_pc got %h want 0010", pc); end
  endtask

  task automatic test_startup();
    logic [3:0] hdr [10];
    hdr = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      tests++; if (cs_n !== (c >= CS0 ? 1'b0 : 1'b1)) begin failed++; $display("FAIL start_cs_n c%0d got %b", c, cs_n); end
      tests++; if (vld !== (c >= 12 ? 1'b1 : 1'b0)) begin failed++; $display("FAIL start_vld c%0d got %b", c, vld); end
      if (c >= CS0 && c < CS0 + HDR) begin
        tests++; if (sio_out !== hdr[c - CS0] || oe !== 1'b1) begin failed++; $display("FAIL start_hdr c%0d got %h/%b want %h/1", c, sio_out, oe, hdr[c - CS0]); end
      end
      if (c >= 12) begin
        tests++; if (ctr !== 2'(c) || pc !== 16'h0010 || enc !== mnib(16, c % 4)) begin failed++; $display("FAIL start_word c%0d got ctr%0d pc%h enc%h want ctr%0d pc0010 enc%h", c, ctr, pc, enc, c % 4, mnib(16, c % 4)); end
      end
    end
  endtask

  task automatic test_stream();
    for (int c = 16; c < 48; c++) begin
      int w;
      @(negedge clk);
      w = 16 + (c - 12) / 4;
      tests++; if (vld !== 1'b1 || cs_n !== 1'b0) begin failed++; $display("FAIL stream_vld c%0d got vld%b cs%b", c, vld, cs_n); end
      tests++; if (ctr !== 2'(c) || pc !== 16'(w) || enc !== mnib(w, c % 4)) begin failed++; $display("FAIL stream_word c%0d got ctr%0d pc%h enc%h want ctr%0d pc%h enc%h", c, ctr, pc, enc, c % 4, w, mnib(w, c % 4)); end
    end
  endtask

  task automatic test_redirect_ignored();
    for (int c = 48; c < 56; c++) begin
      int w;
      @(negedge clk);
      w = 16 + (c - 12) / 4;
      tests++; if (vld !== 1'b1 || cs_n !== 1'b0 || pc !== 16'(w) || enc !== mnib(w, c % 4)) begin failed++; $display("FAIL ignored c%0d got vld%b cs%b pc%h enc%h want 1 0 %h %h", c, vld, cs_n, pc, enc, w, mnib(w, c % 4)); end
      if (c == 49) begin redirect = 1'b1; redirect_addr = 16'hBEEF; end
      if (c == 50) redirect = 1'b0;
    end
  endtask

  task automatic test_redirect();
    logic [3:0] an [6];
    an = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    redirect = 1'b1; redirect_addr = 16'h1234;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      redirect = 1'b0;
      tests++; if (cs_n !== (c >= CSR ? 1'b0 : 1'b1)) begin failed++; $display("FAIL redir_cs_n c%0d got %b", c, cs_n); end
      tests++; if (vld !== (c >= 13 ? 1'b1 : 1'b0)) begin failed++; $display("FAIL redir_vld c%0d got %b", c, vld); end
      if (c >= CSR + 2 && c < CSR + 8) begin
        tests++; if (sio_out !== an[c - CSR - 2]) begin failed++; $display("FAIL redir_addr c%0d got %h want %h", c, sio_out, an[c - CSR - 2]); end
      end
      if (c >= 13) begin
        tests++; if (ctr !== 2'(c - 13) || pc !== 16'h1234 || enc !== mnib(16'h1234, c - 13)) begin failed++; $display("FAIL redir_word c%0d got ctr%0d pc%h enc%h", c, ctr, pc, enc); end
      end
    end
  endtask

  // conc=0: plain wrap to 0000; conc=1: redirect to 0100 on the wrapping cycle.
  task automatic test_wrap();
    for (int conc = 0; conc < 2; conc++) begin
      redirect = 1'b1; redirect_addr = 16'hFFFE;
      for (int c = 1; c <= 36; c++) begin
        int d, a;
        logic [3:0] an [6];
        @(negedge clk);
        if (c == 1 || c == 21) redirect = 1'b0;
        d = (c <= 20) ? c : c - 20;
        if (c <= 20)       begin a = 32'hFFFE; an = '{4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hC}; end
        else if (conc == 0) begin a = 32'h0000; an = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; end
        else                begin a = 32'h0100; an = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0}; end
        tests++; if (cs_n !== (d >= CSR ? 1'b0 : 1'b1)) begin failed++; $display("FAIL wrap%0d_cs_n c%0d got %b", conc, c, cs_n); end
        tests++; if (vld !== (d >= 13 ? 1'b1 : 1'b0)) begin failed++; $display("FAIL wrap%0d_vld c%0d got %b", conc, c, vld); end
        if (d >= CSR + 2 && d < CSR + 8) begin
          tests++; if (sio_out !== an[d - CSR - 2]) begin failed++; $display("FAIL wrap%0d_addr c%0d got %h want %h", conc, c, sio_out, an[d - CSR - 2]); end
        end
        if (d >= 13) begin
          int w;
          w = a + (d - 13) / 4;
          tests++; if (pc !== 16'(w) || enc !== mnib(w, (d - 13) % 4)) begin failed++; $display("FAIL wrap%0d_word c%0d got pc%h enc%h want pc%h enc%h", conc, c, pc, enc, 16'(w), mnib(w, (d - 13) % 4)); end
        end
        if (c == 20 && conc == 1) begin redirect = 1'b1; redirect_addr = 16'h0100; end
      end
    end
  endtask

  task automatic test_async_reset();
    tests++; if (vld !== 1'b1 || cs_n !== 1'b0) begin failed++; $display("FAIL arst_pre got vld%b cs%b want 1 0", vld, cs_n); end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    tests++; if (cs_n !== 1'b1 || vld !== 1'b0) begin failed++; $display("FAIL arst_now got cs%b vld%b want 1 0", cs_n, vld); end
    tests++; if (ctr !== 2'd0 || pc !== 16'h0010 || oe !== 1'b0) begin failed++; $display("FAIL arst_regs got ctr%0d pc%h oe%b", ctr, pc, oe); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      tests++; if (cs_n !== (c >= CS0 ? 1'b0 : 1'b1) || vld !== (c >= 12 ? 1'b1 : 1'b0)) begin failed++; $display("FAIL arst_restart c%0d got cs%b vld%b", c, cs_n, vld); end
      if (c >= 12) begin
        tests++; if (ctr !== 2'(c) || pc !== 16'h0010 || enc !== mnib(16, c % 4)) begin failed++; $display("FAIL arst_word c%0d got ctr%0d pc%h enc%h", c, ctr, pc, enc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stream();
    test_redirect_ignored();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/idli_fetch_m.md
# idli_fetch_m

Instruction fetch unit: the producing end of the nibble-serial encoding stream consumed by the execution stage. Owns the sync counter, runs SQI sequential-read transactions on the external SRAM and forwards each returned nibble, aligned to that counter, with a per-nibble valid flag. Also restarts fetch on a redirect from the execution stage and on 16-bit address wrap-around.

## Interface
- RESET_ADDR, 16'h0000, word address fetched first after reset
- i_fe_gck  in  1  gated core clock; SRAM clock is its inverse, generated externally
- i_ex_rst_n  in  1  reset, asynchronous, active-low
- o_fe_cs_n  out  1  SRAM chip select, active-low
- o_fe_sio_out  out  4  SQI output nibble
- o_fe_sio_oe  out  1  SQI output enable
- i_fe_sio_in  in  4  SQI input nibble
- o_fe_ctr  out  2  sync counter (ctr_t); 0 = first nibble of a word
- o_fe_enc  out  4  encoding nibble (data_t)
- o_fe_enc_vld  out  1  o_fe_enc belongs to a valid word
- o_fe_pc  out  16  word address of the word currently on o_fe_enc
- i_fe_redirect  in  1  redirect request; sampled only when o_fe_ctr == 3
- i_fe_redirect_addr  in  16  new word address

## Operation
- o_fe_ctr free-runs 0,1,2,3,0… from reset; never stalls.
- States: IDLE, CMD (2 cycles), ADDR (6), DUMMY (2), DATA.
- IDLE -> CMD on the cycle with o_fe_ctr == 1 (== 3 without dummy; see Configuration). CS_n low for the whole of CMD..DATA.
- CMD drives 4'h0 then 4'h3 (READ 0x03). ADDR drives byte address {7'b0, fetch_addr, 1'b0}, most significant nibble first. DUMMY drives 4'h0. oe = 1 in CMD/ADDR/DUMMY, 0 otherwise.
- DATA: i_fe_sio_in sampled each cycle into o_fe_enc (one register). The first DATA cycle always has o_fe_ctr == 3, so the first nibble is presented with o_fe_ctr == 0. Nibbles are forwarded in memory order, unmodified.
- o_fe_enc_vld = 1 while registered nibbles come from DATA, else 0.
- o_fe_pc loads fetch_addr with the first nibble and increments by 1 at each o_fe_ctr == 3 -> 0 boundary while in DATA.
- Redirect: i_fe_redirect is accepted only when o_fe_ctr == 3, in any state. The next cycle has CS_n = 1, state IDLE, fetch_addr = i_fe_redirect_addr, and o_fe_enc_vld = 0. The nibble sampled on the accepting cycle is discarded. Fetch restarts at the next o_fe_ctr == 1.
- Wrap: when the word at 16'hFFFF completes in DATA, the unit behaves as a redirect to 16'h0000. The SRAM would otherwise continue at byte 0x20000. A simultaneous external redirect takes priority.
- i_fe_redirect when o_fe_ctr != 3: ignored, no effect.

## Timing
- Reset values: o_fe_ctr 0, o_fe_cs_n 1, o_fe_sio_out 0, o_fe_sio_oe 0, o_fe_enc 0, o_fe_enc_vld 0, o_fe_pc RESET_ADDR, state IDLE.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); CS_n high.
- Reset release is cycle 0. CS_n falls at cycle 1. The first valid nibble appears at cycle 12 (ctr 0), and the first word is complete at cycle 15.
- Redirect accepted at cycle t (ctr 3): CS_n high for cycle t+1 only, CS_n falls at t+2, and the first new valid nibble appears at t+13.
- Steady state: one nibble per cycle, one word per 4 cycles, no bubbles.

## Configuration
- IDLI_FE_DUMMY_EN defined: the 2-cycle DUMMY phase is present. The header is 10 cycles and the transaction starts at o_fe_ctr == 1.
- Not defined: DUMMY is omitted. The header is 8 cycles and the transaction starts at o_fe_ctr == 3. Restart latency after a redirect at cycle t: CS_n falls at t+4 and the first valid nibble appears at t+13.
- In both cases the first data nibble lands at o_fe_ctr == 0.

## Test plan
- Reset release, RESET_ADDR = 16'h0010, SRAM model preloaded: sio_out sequence 0,3,0,0,0,0,2,0,0,0 from cycle 1. o_fe_enc_vld rises at cycle 12 with o_fe_ctr = 0 and o_fe_pc = 16'h0010.
- Stream of 8 words: each word's nibbles match memory in order. o_fe_pc increments at each ctr 3->0 boundary, and o_fe_enc_vld never drops.
- Redirect to 16'h1234 at ctr 3 mid-stream: o_fe_enc_vld = 0 for 12 cycles and CS_n is high for 1 cycle. ADDR nibbles are 0,0,2,4,6,8, and o_fe_pc = 16'h1234 on the first new nibble.
- Redirect pulsed at ctr 1: no change to CS_n, o_fe_pc or the stream.
- Fetch across 16'hFFFF: after that word, the transaction restarts with address nibbles all 0 and o_fe_pc = 16'h0000. A concurrent redirect to 16'h0100 wins instead.
- Async reset asserted in DATA: CS_n goes to 1 and o_fe_enc_vld goes to 0 immediately; after release, the cycle-12 first-nibble timing is repeated.
